// File: rtl/bp_pkg.sv
// Branch predictor package: default geometry and shared helper functions
// for the counter table and its index generation.
package bp_pkg;

    localparam int BP_N_ENTRIES = 64;
    localparam int BP_CNT_W     = 2;
    localparam int BP_HIST_W    = 6;
    localparam int BP_PC_W      = 32;

    // Saturating step of a counter of 'width' bits (width up to 32) toward 'take'.
    function automatic logic [31:0] sat_next(input logic [31:0] cnt,
                                             input logic        take,
                                             input int          width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        if (take)
            return (cnt >= max_v) ? max_v : cnt + 32'd1;
        return (cnt == '0) ? '0 : cnt - 32'd1;
    endfunction

    // Word-aligned PC bits [idx_w+1:2] form the bimodal index.
    function automatic logic [31:0] bp_base_idx(input logic [63:0] pc,
                                                input int          idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

endpackage

// File: rtl/bp_ghr.sv
// Speculative global history register for gshare indexing.
// Fetch shifts in each prediction; a retiring mispredict rebuilds the
// history from the branch's own snapshot plus its resolved direction.
module bp_ghr
    import bp_pkg::*;
#(
    parameter int HIST_W = BP_HIST_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic              pred_take,
    input  logic              upd_valid,
    input  logic              upd_mispredict,
    input  logic              upd_take,
    input  logic [HIST_W-1:0] upd_ghr,
    output logic [HIST_W-1:0] ghr
);

    // Recovery beats the speculative shift; the cast drops the oldest bit,
    // which also covers a single-bit history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (upd_valid && upd_mispredict)
            ghr <= HIST_W'({upd_ghr, upd_take});
        else if (pred_valid)
            ghr <= HIST_W'({ghr, pred_take});
    end

endmodule

// File: rtl/bp_table.sv
// Branch direction predictor: N_ENTRIES saturating counters indexed by PC.
// Lookup is combinational; retire updates land on the clock edge with no
// bypass to a same-cycle lookup.
// Define BP_GSHARE_EN for gshare indexing (PC XOR speculative history).
module bp_table
    import bp_pkg::*;
#(
    parameter  int N_ENTRIES = BP_N_ENTRIES,
    parameter  int CNT_W     = BP_CNT_W,
    parameter  int HIST_W    = BP_HIST_W,
    parameter  int PC_W      = BP_PC_W,
    localparam int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_take,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_take,
    input  logic              upd_mispredict,
    input  logic [HIST_W-1:0] upd_ghr
);

    logic [IDX_W-1:0] base_idx;
    logic [CNT_W-1:0] cnt_q [N_ENTRIES];

    assign base_idx  = IDX_W'(bp_base_idx(64'(pred_pc), IDX_W));
    assign pred_take = cnt_q[pred_idx][CNT_W-1];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr;

    bp_ghr #(.HIST_W(HIST_W)) u_ghr (
        .clock          (clock),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_take      (pred_take),
        .upd_valid      (upd_valid),
        .upd_mispredict (upd_mispredict),
        .upd_take       (upd_take),
        .upd_ghr        (upd_ghr),
        .ghr            (ghr)
    );

    assign pred_idx = base_idx ^ IDX_W'(ghr);
    assign pred_ghr = ghr;
`else
    // Bimodal: history inputs are accepted but have no effect.
    logic unused_gshare;
    assign unused_gshare = ^{upd_ghr, upd_mispredict, pred_valid};
    assign pred_idx      = base_idx;
    assign pred_ghr      = '0;
`endif

    // Counter table: cleared to strongly-not-taken, one saturating step per retire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++)
                cnt_q[i] <= '0;
        end else if (upd_valid) begin
            cnt_q[upd_idx] <= CNT_W'(sat_next(32'(cnt_q[upd_idx]), upd_take, CNT_W));
        end
    end

endmodule

// File: tb/tb_bp_table.sv
// Self-checking bench for bp_table: a default (2-bit) instance and a 3-bit
// counter instance share clock and reset. Expected values are queued when
// stimulus is driven and popped when the outputs are sampled.
// Gshare scenarios are compiled in when BP_GSHARE_EN is defined.
module tb_bp_table;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_take;
    logic [5:0]  pred_idx;
    logic [5:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic        upd_take = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [5:0]  upd_ghr = '0;

    logic        b_pred_valid = 1'b0;
    logic [31:0] b_pred_pc = 32'h40;
    logic        b_pred_take;
    logic [5:0]  b_pred_idx;
    logic [5:0]  b_pred_ghr;
    logic        b_upd_valid = 1'b0;
    logic [5:0]  b_upd_idx = 6'd16;
    logic        b_upd_take = 1'b0;
    logic        b_upd_mispredict = 1'b0;
    logic [5:0]  b_upd_ghr = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    bp_table dut (
        .clock(clock), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_take(pred_take), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_take(upd_take),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr)
    );

    bp_table #(.CNT_W(3)) dut_b (
        .clock(clock), .reset(reset),
        .pred_valid(b_pred_valid), .pred_pc(b_pred_pc),
        .pred_take(b_pred_take), .pred_idx(b_pred_idx), .pred_ghr(b_pred_ghr),
        .upd_valid(b_upd_valid), .upd_idx(b_upd_idx), .upd_take(b_upd_take),
        .upd_mispredict(b_upd_mispredict), .upd_ghr(b_upd_ghr)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: got no summary, want finish before 200000");
        $fatal(1);
    end

    task automatic push(input logic [31:0] exp, input string tag);
        sb_q.push_back('{exp, tag});
    endtask

    task automatic do_upd(input logic [5:0] idx, input logic take);
        @(negedge clock);
        upd_valid = 1'b1; upd_idx = idx; upd_take = take;
        @(negedge clock);
        upd_valid = 1'b0;
    endtask

    task automatic do_upd_b(input logic take);
        @(negedge clock);
        b_upd_valid = 1'b1; b_upd_take = take;
        @(negedge clock);
        b_upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [4];
        logic [5:0]  idx_exp [4];
        sb_t e;
        pcs = '{32'h0000_0040, 32'h0000_0000, 32'hFFFF_FFFC, 32'h1234_5678};
        idx_exp = '{6'd16, 6'd0, 6'd63, 6'd30};
        for (int i = 0; i < 4; i++) begin
            pred_pc = pcs[i];
            push(32'd0, "reset_take");
            push(32'(idx_exp[i]), "reset_idx");
            #1;
            e = sb_q.pop_front(); n_cmp++;
            if (32'(pred_take) !== e.exp) begin
                n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
            end
            e = sb_q.pop_front(); n_cmp++;
            if (32'(pred_idx) !== e.exp) begin
                n_err++; $display("FAIL %s: got %0d want %0d", e.tag, pred_idx, e.exp);
            end
        end
        push(32'd0, "reset_ghr");
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_ghr) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_ghr, e.exp);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_training();
        logic exp_t [5];
        sb_t e;
        exp_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pred_pc = 32'h40;
        push(32'd0, "train_init");
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
        for (int i = 0; i < 4; i++) begin
            push(32'(exp_t[i]), "train_up");
            do_upd(6'd16, 1'b1);
            #1;
            e = sb_q.pop_front(); n_cmp++;
            if (32'(pred_take) !== e.exp) begin
                n_err++; $display("FAIL %s[%0d]: got %0h want %0h", e.tag, i, pred_take, e.exp);
            end
        end
        push(32'd1, "train_down");
        do_upd(6'd16, 1'b0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
        // one more not-taken from 2 must flip the prediction
        push(32'd0, "train_down2");
        do_upd(6'd16, 1'b0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
    endtask

    task automatic test_collision();
        sb_t e;
        do_upd(6'd5, 1'b1);
        pred_pc = 32'h14;
        upd_valid = 1'b1; upd_idx = 6'd5; upd_take = 1'b1;
        push(32'd0, "collide_same");
        push(32'd1, "collide_next");
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
        @(negedge clock);
        upd_valid = 1'b0;
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
    endtask

    task automatic test_cnt3();
        logic exp_d [4];
        sb_t e;
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) do_upd_b(1'b1);
        push(32'd1, "cnt3_sat");
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(b_pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, b_pred_take, e.exp);
        end
        for (int i = 0; i < 4; i++) begin
            push(32'(exp_d[i]), "cnt3_down");
            do_upd_b(1'b0);
            #1;
            e = sb_q.pop_front(); n_cmp++;
            if (32'(b_pred_take) !== e.exp) begin
                n_err++; $display("FAIL %s[%0d]: got %0h want %0h", e.tag, i, b_pred_take, e.exp);
            end
        end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        logic [5:0] bases [4];
        logic       exp_t [4];
        logic [5:0] exp_g [4];
        sb_t e;
        bases = '{6'd30, 6'd0, 6'd28, 6'd27};
        exp_t = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_g = '{6'd0, 6'd1, 6'd2, 6'd5};
        @(negedge clock);
        reset = 1'b1; #1 reset = 1'b0;
        do_upd(6'd30, 1'b1);
        do_upd(6'd30, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1;
            pred_pc = 32'(bases[i]) << 2;
            push(32'(exp_t[i]), "gs_take");
            push(32'(exp_g[i]), "gs_ghr");
            #1;
            e = sb_q.pop_front(); n_cmp++;
            if (32'(pred_take) !== e.exp) begin
                n_err++; $display("FAIL %s[%0d]: got %0h want %0h", e.tag, i, pred_take, e.exp);
            end
            e = sb_q.pop_front(); n_cmp++;
            if (32'(pred_ghr) !== e.exp) begin
                n_err++; $display("FAIL %s[%0d]: got %0h want %0h", e.tag, i, pred_ghr, e.exp);
            end
            @(negedge clock);
        end
        pred_valid = 1'b0;
        push(32'h0B, "gs_ghr_final");
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_ghr) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_ghr, e.exp);
        end
        // recovery and speculative shift in the same cycle
        pred_valid = 1'b1; pred_pc = 32'h40;
        upd_valid = 1'b1; upd_mispredict = 1'b1; upd_ghr = 6'b000010;
        upd_take = 1'b1; upd_idx = 6'd40;
        push(32'h05, "gs_recover");
        push(32'd21, "gs_idx");
        @(negedge clock);
        pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_ghr) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_ghr, e.exp);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_idx) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0d want %0d", e.tag, pred_idx, e.exp);
        end
        // mispredict without upd_valid leaves history alone
        upd_mispredict = 1'b1; upd_ghr = 6'h3F;
        push(32'h05, "gs_ignore_misp");
        @(negedge clock);
        upd_mispredict = 1'b0;
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_ghr) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_ghr, e.exp);
        end
    endtask
`endif

    task automatic test_async_reset();
        sb_t e;
`ifdef BP_GSHARE_EN
        pred_pc = 32'(6'd16 ^ 6'd5) << 2;
`else
        pred_pc = 32'h40;
`endif
        for (int i = 0; i < 3; i++) do_upd(6'd16, 1'b1);
        push(32'd1, "ar_before");
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
        #1 reset = 1'b1;
        pred_pc = 32'h40;
        push(32'd0, "ar_take");
        push(32'd0, "ar_ghr");
        push(32'd0, "ar_b_take");
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_take, e.exp);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_ghr) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, pred_ghr, e.exp);
        end
        e = sb_q.pop_front(); n_cmp++;
        if (32'(b_pred_take) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0h want %0h", e.tag, b_pred_take, e.exp);
        end
        #1 reset = 1'b0;
        push(32'd16, "ar_idx_after");
        @(negedge clock);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (32'(pred_idx) !== e.exp) begin
            n_err++; $display("FAIL %s: got %0d want %0d", e.tag, pred_idx, e.exp);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_collision();
        test_cnt3();
`ifdef BP_GSHARE_EN
        test_gshare();
`endif
        test_async_reset();
        if (sb_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_table.md
Name: bp_table

Overview:
- Parametrised branch direction predictor: a table of N saturating counters indexed by fetch PC; successor to the single-counter 2-bit predictor.
- Sits between fetch, which does a same-cycle lookup, and ROB retire, which updates the counters and corrects the history on mispredict.
- Supports any counter width and table depth.
- Optional gshare indexing with a speculative global history register (GHR) and mispredict recovery.

Parameters:
- N_ENTRIES, 64, number of counters; power of two, ≥2; IDX_W = $clog2(N_ENTRIES).
- CNT_W, 2, counter width in bits; ≥1.
- HIST_W, 6, GHR width; 1 ≤ HIST_W ≤ IDX_W; used only with gshare.
- PC_W, 32, PC width; PC_W ≥ IDX_W+2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pred_valid  in  1  fetch lookup this cycle.
- pred_pc  in  PC_W  PC of the branch being predicted.
- pred_take  out  1  predicted direction; combinational.
- pred_idx  out  IDX_W  table index used; the ROB carries it to update.
- pred_ghr  out  HIST_W  GHR value before this prediction's shift; the ROB carries it.
- upd_valid  in  1  retire update this cycle.
- upd_idx  in  IDX_W  index to update.
- upd_take  in  1  resolved direction.
- upd_mispredict  in  1  resolved direction ≠ predicted.
- upd_ghr  in  HIST_W  pred_ghr snapshot carried with the branch.

Behaviour:
- Reset (async, immediate):
  - Every counter clears to 0 (strongly not-taken).
  - GHR clears to 0.
  - pred_take therefore reads 0 immediately.
- Index:
  - base = pred_pc[IDX_W+1:2].
  - pred_idx = base, or base XOR zero-extended GHR when gshare is enabled.
- Prediction:
  - pred_take = MSB of counter[pred_idx].
  - Combinational, zero latency.
  - Valid regardless of pred_valid; pred_valid only gates the GHR shift.
- Counter update, on a clock edge with upd_valid=1:
  - upd_take=1: counter[upd_idx] increments, saturating at 2^CNT_W−1.
  - upd_take=0: counter[upd_idx] decrements, saturating at 0.
  - With CNT_W=2 this gives exactly SN→WN→WT→ST, with hysteresis on the way back.
  - With upd_valid=0, no counter changes.
- Same-cycle read/write to the same index: the prediction returns the pre-update value (no bypass). The new value is visible the next cycle.
- Only one update per cycle; the ROB serialises branch retires.
- GHR, gshare only. Priority on each edge:
  1. upd_valid & upd_mispredict: GHR ← {upd_ghr[HIST_W−2:0], upd_take}. This repairs the history to the state after the branch; any same-cycle speculative shift is discarded.
  2. Otherwise, pred_valid: GHR ← {GHR[HIST_W−2:0], pred_take}.
  3. Otherwise, GHR holds.
  - For HIST_W=1 the shifted value is just the new bit.
- upd_mispredict without upd_valid is ignored.
- upd_mispredict does not alter counter arithmetic; the counter moves toward upd_take as above.
- Reset asserted mid-operation: the table and GHR are cleared regardless of the update/predict inputs that cycle. Any in-flight ROB snapshots are the ROB's responsibility to flush.
- No X on outputs after reset. upd_idx is always in range by construction because N_ENTRIES is a power of two.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined: GHR register present; XOR indexing, speculative shift and mispredict recovery as above; pred_ghr = GHR.
- Undefined:
  - Pure bimodal indexing (pred_idx = base).
  - No GHR flops.
  - pred_ghr driven 0.
  - upd_ghr and upd_mispredict are unused; they are ignored, not errors.

Decomposition:
- Package bp_pkg holds:
  - the default parameter constants;
  - function sat_next(cnt, take) for saturating increment/decrement at a given width;
  - helper function bp_base_idx(pc).
- One natural sub-module, bp_ghr: the history register with speculative shift and recovery. It is instantiated only under BP_GSHARE_EN.
- The counter array stays in bp_table as a flop array with async clear.

Test Plan:
- Reset, bimodal, defaults: any pred_pc → pred_take=0; pred_idx=pc[7:2]; with pc=0x0000_0040, pred_idx=16.
- Training: four updates with idx=16, take=1 → counter 0→1→2→3→3. pred_take reads 0, 0, 1, 1, 1 on the cycles after each update. Then one update with take=0 → counter 2, pred_take still 1.
- Collision: predict idx 5 while updating idx 5 to taken in the same cycle from counter 1 → pred_take=0 that cycle, 1 the next.
- CNT_W=3: eight taken updates → counter saturates at 7. Then three not-taken updates → 4, pred_take=1. Fourth not-taken → 3, pred_take=0.
- BP_GSHARE_EN, HIST_W=6:
  - Four pred_valid cycles with predictions 1,0,1,1 → GHR=6'b001011.
  - Then upd_valid, mispredict, upd_ghr=6'b000010, upd_take=1, with pred_valid high in the same cycle → GHR=6'b000101 (recovery wins).
  - pred_idx for pc=0x40 then equals 16^5=21.
- Async reset pulse between clock edges mid-training → all counters and GHR read 0 before the next edge; pred_take=0.
